gate_vector_sequencer: RTL and testbench
========================================

Name: gate_vector_sequencer

Overview:
- Clocked stimulus and check stage that sits directly upstream of a combinational gate-under-test, such as the and_gate/not_gate NAND chain.
- Walks every input combination, waits a settle time, samples the gate output and compares it against a parameterised truth table.
- Reports an error count, the first failing vector and pass/done.
- Replaces hand-written delay-and-check sequences with a reusable, synthesizable checker.

Parameters:
- N_INPUTS, 2, number of gate inputs; stimulus width; range 1..4.
- SETTLE_CYCLES, 1, clock cycles stimulus is held before sampling; minimum 1.
- TRUTH_TABLE, 4'b0111 (NAND), 2**N_INPUTS bits; bit i is the expected output for stimulus value i.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- dut_r  in  1  output of the gate-under-test.
- stim  out  N_INPUTS  drive vector to the gate inputs; LSB is the last input (b), MSB is the first (a).
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  N_INPUTS+1  number of mismatching vectors in the current or last sweep.
- first_fail_vec  out  N_INPUTS  stimulus value of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE immediately.
  - stim, err_count, first_fail_vec = 0.
  - busy, done, pass, first_fail_valid = 0.
  - Reset asserted mid-sweep aborts the sweep; no partial result is retained.
- States: IDLE, SETTLE, CHECK, DONE. All registers are updated on the rising clk edge.
- IDLE:
  - start=1 -> SETTLE.
  - Load stim=0 and settle counter=SETTLE_CYCLES-1.
  - Clear err_count, first_fail_valid and first_fail_vec.
- SETTLE:
  - stim is held stable.
  - Counter decrements each cycle; at counter==0 -> CHECK.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - dut_r is sampled on the edge leaving CHECK.
  - Mismatch when dut_r != TRUTH_TABLE[stim]. On mismatch, err_count increments.
  - If first_fail_valid=0 on a mismatch, capture first_fail_vec=stim and set first_fail_valid.
  - If stim == 2**N_INPUTS-1 -> DONE; stim stays at the last vector.
  - Otherwise stim increments, the counter reloads and the state returns to SETTLE.
- DONE:
  - done=1; pass=(err_count==0).
  - Results hold until start=1, which restarts exactly as from IDLE (counters cleared the same edge).
- Latency:
  - Start accepted at edge E0.
  - stim=0 is visible after E0.
  - done rises after edge E0 + 2**N_INPUTS*(SETTLE_CYCLES+1). Defaults give 8 cycles.
- start while busy is ignored.
- dut_r is don't-care outside CHECK; X on dut_r in CHECK counts as a mismatch.
- err_count never wraps: its maximum is 2**N_INPUTS, which fits in N_INPUTS+1 bits.
- stim changes only on CHECK->SETTLE edges, so no glitch reaches the gate between samples.
- Outputs are registered or decoded from state only; there is no combinational path from dut_r to any output.

Decomposition:
- Package gate_test_pkg contains:
  - the state typedef (enum logic [1:0] {IDLE, SETTLE, CHECK, DONE});
  - truth-table constants TT_NAND2=4'b0111, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_NOT1=2'b01.
- No sub-module: the settle counter is a small inline register.
- Benches instantiate gate_vector_sequencer alongside and_gate and not_gate.

Test Plan:
- Correct DUT:
  - Stimulus: and_gate->not_gate chain with TT_NAND2 and SETTLE_CYCLES=1; pulse start.
  - Response: stim sequence 0,0,1,1,2,2,3,3 (per cycle); done after 8 cycles; err_count=0; pass=1; first_fail_valid=0.
- Wrong truth table:
  - Stimulus: same chain but TRUTH_TABLE=TT_AND2.
  - Response: err_count=4; pass=0; first_fail_vec=0; first_fail_valid=1.
- Stuck-at-0 DUT:
  - Stimulus: dut_r tied 0 with TT_NAND2.
  - Response: err_count=3; first_fail_vec=0. Then dut_r tied 1 gives err_count=1, first_fail_vec=3.
- Longer settle time:
  - Stimulus: SETTLE_CYCLES=3.
  - Response: each stim value held 4 cycles; done 16 cycles after start.
- Start while busy, then reset mid-sweep:
  - Stimulus: pulse start again mid-sweep; then assert rst mid-sweep (between edges).
  - Response: the repeated start has no effect on stim or timing. On rst, all outputs go to 0 immediately, before the next clk edge. After release, a new start gives a full clean sweep.
- Restart from DONE:
  - Stimulus: after a failing sweep, switch to a correct DUT and pulse start.
  - Response: err_count and first_fail_valid clear on the start edge; final result pass=1.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the gate vector sequencer.
// Bit i of a truth table is the expected gate output for stimulus value i.
package gate_test_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [1:0] TT_NOT1  = 2'b01;

endpackage

// File: rtl/and_gate.sv
// Two-input combinational AND, used as the first stage of a NAND chain under test.
module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic r_o
);

  assign r_o = a_i & b_i;

endmodule

// File: rtl/not_gate.sv
// Combinational inverter, used as the second stage of a NAND chain under test.
module not_gate (
  input  logic a_i,
  output logic r_o
);

  assign r_o = ~a_i;

endmodule

// File: rtl/gate_vector_sequencer.sv
// Sweeps every input vector of a combinational gate, holds each for SETTLE_CYCLES,
// then samples the gate output against TRUTH_TABLE; reports error count, first failure, pass/done.
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [2**N_INPUTS-1:0] TRUTH_TABLE = TT_NAND2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dut_r,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [N_INPUTS-1:0] stim_q;
  logic [N_INPUTS:0]   err_q;
  logic [N_INPUTS-1:0] ffv_q;
  logic                ffvalid_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                mismatch_d;

  // An unknown dut_r takes the else branch, so it is scored as a mismatch.
  always_comb begin
    mismatch_d = 1'b1;
    if (dut_r == TRUTH_TABLE[stim_q]) begin
      mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stim_q    <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= SETTLE;
            cnt_q     <= CNT_INIT;
            stim_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CHECK: begin
          if (mismatch_d) begin
            err_q <= err_q + 1'b1;
            if (!ffvalid_q) begin
              ffv_q     <= stim_q;
              ffvalid_q <= 1'b1;
            end
          end
          // stim only moves here, so the gate inputs never change mid-settle.
          if (stim_q == '1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !mismatch_d;
          end else begin
            state_q <= SETTLE;
            stim_q  <= stim_q + 1'b1;
            cnt_q   <= CNT_INIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer driving and_gate/not_gate NAND chains,
// with a queue of expected values filled before each sweep and drained as the DUT responds.
module tb_gate_vector_sequencer;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  int   mode_a = 0;
  int   sel = 0;

  logic [1:0] stim_a, stim_b, stim_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c;
  logic [2:0] err_a, err_b, err_c;
  logic [1:0] ffv_a, ffv_b, ffv_c;
  logic       ffval_a, ffval_b, ffval_c;
  logic       and_a, nand_a, and_b, nand_b, and_c, nand_c;
  logic       dut_r_a;

  always #5 clk = ~clk;

  and_gate u_and_a (.a_i(stim_a[1]), .b_i(stim_a[0]), .r_o(and_a));
  not_gate u_not_a (.a_i(and_a), .r_o(nand_a));
  and_gate u_and_b (.a_i(stim_b[1]), .b_i(stim_b[0]), .r_o(and_b));
  not_gate u_not_b (.a_i(and_b), .r_o(nand_b));
  and_gate u_and_c (.a_i(stim_c[1]), .b_i(stim_c[0]), .r_o(and_c));
  not_gate u_not_c (.a_i(and_c), .r_o(nand_c));

  assign dut_r_a = (mode_a == 0) ? nand_a : (mode_a == 1) ? 1'b0 : 1'b1;

  gate_vector_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1), .TRUTH_TABLE(TT_NAND2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_r(dut_r_a), .stim(stim_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffval_a));

  gate_vector_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1), .TRUTH_TABLE(TT_AND2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_r(nand_b), .stim(stim_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffval_b));

  gate_vector_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(3), .TRUTH_TABLE(TT_NAND2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_r(nand_c), .stim(stim_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ffv_c), .first_fail_valid(ffval_c));

  logic [1:0] o_stim, o_ffv;
  logic [2:0] o_err;
  logic       o_busy, o_done, o_pass, o_ffval;

  always_comb begin
    o_stim = stim_a; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
    o_err = err_a; o_ffv = ffv_a; o_ffval = ffval_a;
    case (sel)
      1: begin
        o_stim = stim_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
        o_err = err_b; o_ffv = ffv_b; o_ffval = ffval_b;
      end
      2: begin
        o_stim = stim_c; o_busy = busy_c; o_done = done_c; o_pass = pass_c;
        o_err = err_c; o_ffv = ffv_c; o_ffval = ffval_c;
      end
      default: ;
    endcase
  end

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL %s: observed %0h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 7; i++) exp_q.push_back(32'd0);
    chk({tag, ".stim"}, 32'(o_stim));
    chk({tag, ".busy"}, 32'(o_busy));
    chk({tag, ".done"}, 32'(o_done));
    chk({tag, ".pass"}, 32'(o_pass));
    chk({tag, ".err"}, 32'(o_err));
    chk({tag, ".ffv"}, 32'(o_ffv));
    chk({tag, ".ffval"}, 32'(o_ffval));
  endtask

  // mode: 0 = NAND chain, 1 = output stuck at 0, 2 = output stuck at 1 (instance a only)
  task automatic sweep(input string tag, input int s, input int settle, input int mode,
                       input bit poke);
    logic [3:0] tt;
    int err, ffv, tlen, r;
    bit ffval;
    tt = (s == 1) ? TT_AND2 : TT_NAND2;
    err = 0; ffv = 0; ffval = 0;
    tlen = 4 * (settle + 1);
    for (int v = 0; v < 4; v++) begin
      r = (mode == 0) ? ((v == 3) ? 0 : 1) : (mode == 1) ? 0 : 1;
      if (r != int'(tt[v])) begin
        err++;
        if (!ffval) begin ffv = v; ffval = 1; end
      end
    end
    for (int k = 0; k < tlen; k++) begin
      exp_q.push_back(32'(k / (settle + 1)));
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      if (k == 0) begin exp_q.push_back(32'd0); exp_q.push_back(32'd0); end
    end
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'(err));
    exp_q.push_back(32'(err == 0));
    exp_q.push_back(32'(ffval));
    exp_q.push_back(32'(ffv));

    sel = s;
    if (s == 0) mode_a = mode;
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    for (int k = 0; k < tlen; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (poke) set_start(s, k == 2);
      chk({tag, ".stim"}, 32'(o_stim));
      chk({tag, ".busy"}, 32'(o_busy));
      chk({tag, ".done_early"}, 32'(o_done));
      if (k == 0) begin
        chk({tag, ".err_clr"}, 32'(o_err));
        chk({tag, ".ffval_clr"}, 32'(o_ffval));
      end
    end
    set_start(s, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, ".done"}, 32'(o_done));
    chk({tag, ".busy_end"}, 32'(o_busy));
    chk({tag, ".stim_end"}, 32'(o_stim));
    chk({tag, ".err"}, 32'(o_err));
    chk({tag, ".pass"}, 32'(o_pass));
    chk({tag, ".ffval"}, 32'(o_ffval));
    chk({tag, ".ffv"}, 32'(o_ffv));
  endtask

  initial begin
    sel = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    sweep("nand_ok", 0, 1, 0, 1'b0);
    sweep("wrong_tt", 1, 1, 0, 1'b0);
    sweep("stuck0", 0, 1, 1, 1'b0);
    sweep("stuck1", 0, 1, 2, 1'b0);
    sweep("restart", 0, 1, 0, 1'b0);
    sweep("settle3_poke", 2, 3, 0, 1'b1);

    // Abort a failing sweep with an asynchronous reset between clock edges.
    sel = 0;
    mode_a = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    sweep("after_rst", 0, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
